// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, opcodes
// and the datapath mux/ALU select codes.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RSLT_ALUOUT = 2'b00;
    localparam logic [1:0] RSLT_DATA   = 2'b01;
    localparam logic [1:0] RSLT_ALURES = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the FSM (slave) and the datapath side (master).
interface main_fsm_if;
    logic [6:0] OP;
    logic       MEMRDY;
    logic       IRWRITE;
    logic       PCUPDATE;
    logic       ADRSRC;
    logic       REGWRITE;
    logic       MEMWRITE;
    logic       BRANCH;
    logic [1:0] ALUSRCA;
    logic [1:0] ALUSRCB;
    logic [1:0] RSLTSRC;
    logic [1:0] ALUOP;
    logic [2:0] IMMSRC;
    logic       ILLOP;

    modport master (
        output OP, MEMRDY,
        input  IRWRITE, PCUPDATE, ADRSRC, REGWRITE, MEMWRITE, BRANCH,
        input  ALUSRCA, ALUSRCB, RSLTSRC, ALUOP, IMMSRC, ILLOP
    );

    modport slave (
        input  OP, MEMRDY,
        output IRWRITE, PCUPDATE, ADRSRC, REGWRITE, MEMWRITE, BRANCH,
        output ALUSRCA, ALUSRCB, RSLTSRC, ALUOP, IMMSRC, ILLOP
    );
endinterface

// File: rtl/main_fsm_immsrc_dec.sv
// Immediate-format select decoded straight from the opcode, independent of state.
module immsrc_dec
    import main_fsm_pkg::*;
(
    input  logic [6:0] OP,
    output logic [2:0] IMMSRC
);

    // opcode to immediate format
    always_comb begin
        IMMSRC = IMM_I;
        case (OP)
            OP_LW, OP_ITYPE:  IMMSRC = IMM_I;
            OP_SW:            IMMSRC = IMM_S;
            OP_BEQ:           IMMSRC = IMM_B;
            OP_JAL:           IMMSRC = IMM_J;
            OP_LUI, OP_AUIPC: IMMSRC = IMM_U;
            default:          IMMSRC = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM with a unified, handshaked memory.
// Moore outputs except the MEMRDY-qualified fetch strobes and IMMSRC.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter int EN_UTYPE = 1
) (
    input  logic     CLK,
    input  logic     RST,
    main_fsm_if.slave bus
);

    state_t     state_q, state_n;
    logic       illop_q;
    logic       irwrite, pcupdate, adrsrc, regwrite, memwrite, branch;
    logic [1:0] alusrca, alusrcb, rsltsrc, aluop;
    logic [2:0] immsrc;

    immsrc_dec u_immsrc_dec (
        .OP     (bus.OP),
        .IMMSRC (immsrc)
    );

    // state register and sticky illegal-opcode flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            illop_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (state_n == S_ILLEGAL) illop_q <= 1'b1;
        end
    end

    // next-state and per-state control outputs
    always_comb begin
        state_n  = state_q;
        irwrite  = 1'b0;
        pcupdate = 1'b0;
        adrsrc   = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        alusrca  = SRCA_PC;
        alusrcb  = SRCB_WD;
        rsltsrc  = RSLT_ALUOUT;
        aluop    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb  = SRCB_FOUR;
                rsltsrc  = RSLT_ALURES;
                irwrite  = bus.MEMRDY;
                pcupdate = bus.MEMRDY;
                if (bus.MEMRDY) state_n = S_DECODE;
            end
            S_DECODE: begin
                // precompute the branch target from the old PC
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (bus.OP)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXECR;
                    OP_ITYPE:     state_n = S_EXECI;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_JAL:       state_n = S_JAL;
                    OP_LUI:       state_n = (EN_UTYPE != 0) ? S_LUI : S_ILLEGAL;
                    OP_AUIPC:     state_n = (EN_UTYPE != 0) ? S_AUIPC : S_ILLEGAL;
                    default:      state_n = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_IMM;
                state_n = (bus.OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (bus.MEMRDY) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                rsltsrc  = RSLT_DATA;
                regwrite = 1'b1;
                state_n  = S_FETCH;
            end
            S_MEMWRITE: begin
                // write strobe stays up for the whole wait
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (bus.MEMRDY) state_n = S_FETCH;
            end
            S_EXECR: begin
                alusrca = SRCA_RD1;
                aluop   = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                state_n  = S_FETCH;
            end
            S_JAL: begin
                // PC <= target while ALU forms the link value PC+4
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
                state_n  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca = SRCA_RD1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                state_n = S_FETCH;
            end
            S_LUI: begin
                alusrca = SRCA_ZERO;
                alusrcb = SRCB_IMM;
                state_n = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                state_n = S_ALUWB;
            end
            S_ILLEGAL: state_n = S_ILLEGAL;
            default:   state_n = S_FETCH;
        endcase
    end

    // strobes are masked during reset so nothing is written in that cycle
    assign bus.IRWRITE  = irwrite  & ~RST;
    assign bus.PCUPDATE = pcupdate & ~RST;
    assign bus.REGWRITE = regwrite & ~RST;
    assign bus.MEMWRITE = memwrite & ~RST;
    assign bus.BRANCH   = branch   & ~RST;
    assign bus.ADRSRC   = adrsrc;
    assign bus.ALUSRCA  = alusrca;
    assign bus.ALUSRCB  = alusrcb;
    assign bus.RSLTSRC  = rsltsrc;
    assign bus.ALUOP    = aluop;
    assign bus.IMMSRC   = immsrc;
    assign bus.ILLOP    = illop_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: two instances (U-type enabled / disabled)
// share stimulus; per-cycle expected output vectors go through a scoreboard.
module tb_main_fsm;

    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
    localparam int ST_ER = 6, ST_EI = 7, ST_AWB = 8, ST_J = 9, ST_B = 10;
    localparam int ST_LU = 11, ST_AU = 12, ST_IL = 13;

    localparam logic [6:0] C_LW = 7'b0000011, C_SW = 7'b0100011, C_R = 7'b0110011;
    localparam logic [6:0] C_I = 7'b0010011, C_BEQ = 7'b1100011, C_JAL = 7'b1101111;
    localparam logic [6:0] C_LUI = 7'b0110111, C_AUIPC = 7'b0010111, C_BAD = 7'b0000000;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       memrdy = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [35:0] sbq[$];

    main_fsm_if if1 ();
    main_fsm_if if0 ();
    assign if1.OP = op;
    assign if1.MEMRDY = memrdy;
    assign if0.OP = op;
    assign if0.MEMRDY = memrdy;

    main_fsm #(.EN_UTYPE(1)) dut1 (.CLK(CLK), .RST(rst), .bus(if1.slave));
    main_fsm #(.EN_UTYPE(0)) dut0 (.CLK(CLK), .RST(rst), .bus(if0.slave));

    always #5 CLK = ~CLK;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            C_LW, C_I:      return 3'b000;
            C_SW:           return 3'b001;
            C_BEQ:          return 3'b010;
            C_JAL:          return 3'b011;
            C_LUI, C_AUIPC: return 3'b100;
            default:        return 3'b000;
        endcase
    endfunction

    // expected {IRWRITE,PCUPDATE,ADRSRC,REGWRITE,MEMWRITE,BRANCH,A,B,RSLT,ALUOP,IMM,ILLOP}
    function automatic logic [17:0] expv(input int s, input logic [6:0] o, input logic rdy, input logic rs);
        logic irw, pcu, adr, rw, mw, br, il;
        logic [1:0] a, b, rl, ao;
        irw = 0; pcu = 0; adr = 0; rw = 0; mw = 0; br = 0; il = 0;
        a = 2'b00; b = 2'b00; rl = 2'b00; ao = 2'b00;
        case (s)
            ST_F:   begin b = 2'b10; rl = 2'b10; irw = rdy; pcu = rdy; end
            ST_D:   begin a = 2'b01; b = 2'b01; end
            ST_MA:  begin a = 2'b10; b = 2'b01; end
            ST_MR:  adr = 1;
            ST_MWB: begin rl = 2'b01; rw = 1; end
            ST_MW:  begin adr = 1; mw = 1; end
            ST_ER:  begin a = 2'b10; ao = 2'b10; end
            ST_EI:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
            ST_AWB: rw = 1;
            ST_J:   begin a = 2'b01; b = 2'b10; pcu = 1; end
            ST_B:   begin a = 2'b10; ao = 2'b01; br = 1; end
            ST_LU:  begin a = 2'b11; b = 2'b01; end
            ST_AU:  begin a = 2'b01; b = 2'b01; end
            ST_IL:  il = 1;
            default: ;
        endcase
        if (rs) begin irw = 0; pcu = 0; rw = 0; mw = 0; br = 0; end
        return {irw, pcu, adr, rw, mw, br, a, b, rl, ao, imm_of(o), il};
    endfunction

    function automatic logic [35:0] observed();
        return {if1.IRWRITE, if1.PCUPDATE, if1.ADRSRC, if1.REGWRITE, if1.MEMWRITE, if1.BRANCH,
                if1.ALUSRCA, if1.ALUSRCB, if1.RSLTSRC, if1.ALUOP, if1.IMMSRC, if1.ILLOP,
                if0.IRWRITE, if0.PCUPDATE, if0.ADRSRC, if0.REGWRITE, if0.MEMWRITE, if0.BRANCH,
                if0.ALUSRCA, if0.ALUSRCB, if0.RSLTSRC, if0.ALUOP, if0.IMMSRC, if0.ILLOP};
    endfunction

    // drive one cycle of inputs and push the expectation for both instances
    task automatic drive_push(input int s1, input int s0, input logic [6:0] o, input logic rdy, input logic rs);
        @(negedge CLK);
        op = o; memrdy = rdy; rst = rs;
        sbq.push_back({expv(s1, o, rdy, rs), expv(s0, o, rdy, rs)});
    endtask

    task automatic test_reset();
        logic [35:0] got, exp;
        logic [6:0] oa[2] = '{C_LW, C_JAL};
        rst = 1'b1; memrdy = 1'b1;
        repeat (2) @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            drive_push(ST_F, ST_F, oa[i], 1'b1, 1'b1);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL reset cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_lw();
        logic [35:0] got, exp;
        int sa[6] = '{ST_F, ST_D, ST_MA, ST_MR, ST_MWB, ST_F};
        int ra[6] = '{1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            drive_push(sa[i], sa[i], C_LW, ra[i] != 0, 1'b0);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL lw cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_sw_wait();
        logic [35:0] got, exp;
        int sa[8] = '{ST_F, ST_D, ST_MA, ST_MW, ST_MW, ST_MW, ST_MW, ST_F};
        int ra[8] = '{1, 1, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            drive_push(sa[i], sa[i], C_SW, ra[i] != 0, 1'b0);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL sw cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_beq();
        logic [35:0] got, exp;
        int sa[4] = '{ST_F, ST_D, ST_B, ST_F};
        int ra[4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive_push(sa[i], sa[i], C_BEQ, ra[i] != 0, 1'b0);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL beq cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_jal();
        logic [35:0] got, exp;
        int sa[5] = '{ST_F, ST_D, ST_J, ST_AWB, ST_F};
        int ra[5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive_push(sa[i], sa[i], C_JAL, ra[i] != 0, 1'b0);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL jal cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_utype();
        logic [35:0] got, exp;
        int s1[10] = '{ST_F, ST_D, ST_LU, ST_AWB, ST_F, ST_F, ST_D, ST_AU, ST_AWB, ST_F};
        int s0[10] = '{ST_F, ST_D, ST_IL, ST_IL, ST_IL, ST_IL, ST_IL, ST_IL, ST_IL, ST_IL};
        int ra[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            drive_push(s1[i], s0[i], (i < 5) ? C_LUI : C_AUIPC, ra[i] != 0, 1'b0);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL utype cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] got, exp;
        int s1[9] = '{ST_F, ST_D, ST_ER, ST_AWB, ST_F, ST_D, ST_EI, ST_AWB, ST_F};
        int ra[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            drive_push(s1[i], ST_IL, (i < 4) ? C_R : C_I, ra[i] != 0, 1'b0);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL b2b cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_rst_midread();
        logic [35:0] got, exp;
        int s1[7] = '{ST_F, ST_D, ST_MA, ST_MR, ST_MR, ST_F, ST_F};
        int s0[7] = '{ST_IL, ST_IL, ST_IL, ST_IL, ST_IL, ST_F, ST_F};
        int ra[7] = '{1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            drive_push(s1[i], s0[i], C_LW, ra[i] != 0, i == 4);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL rstread cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_illegal();
        logic [35:0] got, exp;
        int sa[6] = '{ST_F, ST_D, ST_IL, ST_IL, ST_IL, ST_F};
        int ra[6] = '{1, 1, 1, 1, 1, 0};
        logic [6:0] oa[6] = '{C_BAD, C_BAD, C_BAD, C_LW, C_LW, C_LW};
        for (int i = 0; i < 6; i++) begin
            drive_push(sa[i], sa[i], oa[i], ra[i] != 0, i == 4);
            #1; got = observed(); exp = sbq.pop_front(); total++;
            if (got !== exp) begin bad++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_jal();
        test_utype();
        test_back_to_back();
        test_rst_midread();
        test_illegal();
        total++;
        if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard left=%0d required=0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time=%0t limit=50000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; the ports are named CLK and RST.
REQ-002 Parameter EN_UTYPE, default 1, meaning 1 enables LUI (0110111) and AUIPC (0010111) and 0 treats them as illegal.
REQ-003 Port CLK, input, 1 bit: rising-edge clock.
REQ-004 Port RST, input, 1 bit: synchronous active-high reset.
REQ-005 Port OP, input, 7 bits: opcode of the instruction register contents.
REQ-006 Port MEMRDY, input, 1 bit: unified memory has completed the current access.
REQ-007 Outputs SHALL be: IRWRITE (1, instruction-register enable); PCUPDATE (1, unconditional PC write); ADRSRC (1, 0 = PC address, 1 = result address); REGWRITE (1); MEMWRITE (1); BRANCH (1); ALUSRCA (2: 00 PC, 01 OLDPC, 10 RD1, 11 zero); ALUSRCB (2: 00 WD, 01 IMMEXT, 10 constant 4); RSLTSRC (2: 00 ALUOUT, 01 DATA, 10 ALURESULT); ALUOP (2: 00 add, 01 sub, 10 funct); IMMSRC (3: 000 I, 001 S, 010 B, 011 J, 100 U); ILLOP (1, sticky illegal-opcode flag).

Function
REQ-008 The block SHALL be a Moore FSM, except for the MEMRDY qualification in REQ-009/011/013 and the combinational IMMSRC from OP.
REQ-009 FETCH: ADRSRC=0, ALUSRCA=00, ALUSRCB=10, ALUOP=00, RSLTSRC=10; IRWRITE=PCUPDATE=MEMRDY; go to DECODE if MEMRDY=1, else stay.
REQ-010 DECODE: ALUSRCA=01, ALUSRCB=01, ALUOP=00 (branch target). Next state by OP: LW or SW -> MEMADR; R-type -> EXECR; I-type ALU -> EXECI; BEQ -> BEQ; JAL -> JAL; LUI -> LUI and AUIPC -> AUIPC if EN_UTYPE=1; any other opcode -> ILLEGAL.
REQ-011 MEMADR: ALUSRCA=10, ALUSRCB=01, ALUOP=00; go to MEMREAD if OP=LW, else MEMWRITE.
REQ-012 MEMREAD: ADRSRC=1, RSLTSRC=00; go to MEMWB when MEMRDY=1, else hold.
REQ-013 MEMWB: RSLTSRC=01, REGWRITE=1; next state FETCH.
REQ-014 MEMWRITE: ADRSRC=1, RSLTSRC=00, MEMWRITE=1, held while waiting; go to FETCH when MEMRDY=1.
REQ-015 EXECR: ALUSRCA=10, ALUSRCB=00, ALUOP=10; next state ALUWB.
REQ-016 EXECI: ALUSRCA=10, ALUSRCB=01, ALUOP=10; next state ALUWB.
REQ-017 ALUWB: RSLTSRC=00, REGWRITE=1; next state FETCH.
REQ-018 JAL: ALUSRCA=01, ALUSRCB=10, ALUOP=00, RSLTSRC=00, PCUPDATE=1; next state ALUWB.
REQ-019 BEQ: ALUSRCA=10, ALUSRCB=00, ALUOP=01, RSLTSRC=00, BRANCH=1; next state FETCH.
REQ-020 LUI: ALUSRCA=11, ALUSRCB=01, ALUOP=00; next state ALUWB.
REQ-021 AUIPC: ALUSRCA=01, ALUSRCB=01, ALUOP=00; next state ALUWB.
REQ-022 ILLEGAL: ILLOP is set and stays 1; all strobes are 0; the state is terminal until RST.
REQ-023 Unlisted select outputs SHALL be 00 in every state; strobes (IRWRITE, PCUPDATE, REGWRITE, MEMWRITE, BRANCH) SHALL be 0 unless listed.
REQ-024 IMMSRC SHALL be decoded from OP in every state: LW/I-type 000, SW 001, BEQ 010, JAL 011, LUI/AUIPC 100, else 000.
REQ-025 An unused state encoding SHALL return to FETCH on the next clock.
REQ-026 Cycle counts with MEMRDY held at 1: LW 5; SW, R, I, JAL, LUI, AUIPC 4; BEQ 3. Each MEMRDY=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Reset
REQ-027 With RST=1 at a clock edge, the state SHALL become FETCH and ILLOP 0, from any state including a mid-instruction wait.
REQ-028 While RST=1, all strobes SHALL be forced to 0 combinationally, so no write occurs in the reset cycle.

Structure
REQ-029 Package main_fsm_pkg SHALL hold the state enum, the opcode constants, and the ALUSRCA/ALUSRCB/RSLTSRC/ALUOP/IMMSRC encodings.
REQ-030 IMMSRC decoding SHALL be a sub-module, immsrc_dec (combinational, OP in, IMMSRC out); the FSM is the parent.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- RST=1 then OP=0000011, MEMRDY=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; REGWRITE=1 only in cycle 5, RSLTSRC=01.
- OP=0100011 with MEMRDY=0 for 3 cycles in MEMWRITE -> MEMWRITE=1 held 4 cycles, then FETCH; no REGWRITE.
- OP=1100011 -> BRANCH=1 in cycle 3, ALUOP=01, IMMSRC=010; back to FETCH in cycle 4.
- OP=1101111 -> PCUPDATE=1 in FETCH and in JAL, REGWRITE in ALUWB, IMMSRC=011.
- OP=0110111 with EN_UTYPE=1 -> ALUSRCA=11 then ALUWB; with EN_UTYPE=0 -> ILLEGAL, ILLOP=1 sticky, cleared only by RST.
- RST asserted during a MEMREAD wait (MEMRDY=0) -> next state FETCH, no REGWRITE pulse, ILLOP=0.
